// File: rtl/watch_set_core.sv
// watch_set_core
//   Time-of-day counter (hour:min:sec.msec) with a button-driven set mode.
//   A free-running divider produces a one-clock tick every CLK_HZ/TICK_HZ
//   clocks. In RUN the tick advances msec with a full carry chain. In the SET
//   states the selected field is stepped by i_up / i_down, with auto-repeat
//   while a button is held.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   i_mode       single-cycle pulse, RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   i_up/i_down  debounced levels, step the selected field +1 / -1
//   msec         sub-second count 0..TICK_HZ-1
//   sec, min     0..59
//   hour         0..23 (HOUR_MODE=24) or 1..12 (HOUR_MODE=12)
//   o_set_field  current mode: 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   o_blink      blink phase for the selected field, 0 in RUN
module watch_set_core #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int HOUR_MODE    = 24,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_mode,
    input  logic                       i_up,
    input  logic                       i_down,
    output logic [$clog2(TICK_HZ)-1:0] msec,
    output logic [5:0]                 sec,
    output logic [5:0]                 min,
    output logic [4:0]                 hour,
    output logic [1:0]                 o_set_field,
    output logic                       o_blink
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MS_W    = $clog2(TICK_HZ);
    localparam int HALF    = (TICK_HZ / 2 > 0) ? TICK_HZ / 2 : 1;
    localparam int BL_W    = $clog2(HALF + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICK_HZ - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(HALF - 1);
    localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RT   = RPT_W'(REPEAT_RATE);
    localparam logic [4:0]       HOUR_LO  = (HOUR_MODE == 12) ? 5'd1  : 5'd0;
    localparam logic [4:0]       HOUR_HI  = (HOUR_MODE == 12) ? 5'd12 : 5'd23;
    localparam logic [4:0]       HOUR_RST = (HOUR_MODE == 12) ? 5'd12 : 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    mode_t state;
    assign o_set_field = state;

    function automatic logic [5:0] m60_inc(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] m60_dec(input logic [5:0] v);
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] hr_inc(input logic [4:0] v);
        return (v >= HOUR_HI) ? HOUR_LO : v + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dec(input logic [4:0] v);
        return (v <= HOUR_LO || v > HOUR_HI) ? HOUR_HI : v - 5'd1;
    endfunction

    // ---------------------------------------------------------------
    // Tick divider. run_en holds the divider at 0 on the first edge after
    // reset so the first tick lands a full period after that edge, the same
    // spacing as after the SET_SEC->RUN restart.
    // ---------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             run_en;
    logic             tick;

    assign tick = run_en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            run_en  <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (!run_en || (i_mode && state == SET_SEC) || div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Button edge detect and auto-repeat.
    // Pressing both buttons counts as neither; a rise is only seen on a
    // button that is pressed alone.
    // ---------------------------------------------------------------
    logic             up_q, down_q;
    logic             rep_act, rep_phase, rep_dir;
    logic [RPT_W-1:0] rep_cnt;
    logic [RPT_W-1:0] rep_next;
    logic             up_only, down_only, up_rise, down_rise, press;
    logic             held_same, rep_hit, step, step_up;

    assign up_only   = i_up & ~i_down;
    assign down_only = i_down & ~i_up;
    assign up_rise   = up_only & ~up_q;
    assign down_rise = down_only & ~down_q;
    assign press     = up_rise | down_rise;
    assign held_same = rep_dir ? up_only : down_only;
    assign rep_next  = rep_cnt + 1'b1;
    assign rep_hit   = rep_act && held_same && tick &&
                       (rep_next == (rep_phase ? RPT_RT : RPT_DLY));
    assign step      = press | rep_hit;
    assign step_up   = press ? up_rise : rep_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            rep_act   <= 1'b0;
            rep_phase <= 1'b0;
            rep_dir   <= 1'b0;
            rep_cnt   <= '0;
        end else begin
            up_q   <= i_up;
            down_q <= i_down;
            if (i_mode || state == RUN || (i_up && i_down) || (rep_act && !held_same)) begin
                rep_act   <= 1'b0;
                rep_phase <= 1'b0;
                rep_cnt   <= '0;
            end else if (press) begin
                rep_act   <= 1'b1;
                rep_phase <= 1'b0;
                rep_dir   <= up_rise;
                rep_cnt   <= '0;
            end else if (rep_act && tick) begin
                if (rep_hit) begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b1;
                end else begin
                    rep_cnt   <= rep_next;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Mode FSM and time fields. A mode pulse wins over both the tick and
    // any pending step on the same edge.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            msec  <= '0;
            sec   <= '0;
            min   <= '0;
            hour  <= HOUR_RST;
        end else if (i_mode) begin
            msec <= '0;
            case (state)
                RUN:      state <= SET_HOUR;
                SET_HOUR: state <= SET_MIN;
                SET_MIN:  state <= SET_SEC;
                default:  state <= RUN;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                if (msec == MS_LAST) begin
                    msec <= '0;
                    sec  <= m60_inc(sec);
                    if (sec == 6'd59) begin
                        min <= m60_inc(min);
                        if (min == 6'd59)
                            hour <= hr_inc(hour);
                    end
                end else begin
                    msec <= msec + 1'b1;
                end
            end
        end else begin
            msec <= '0;
            if (step) begin
                case (state)
                    SET_HOUR: hour <= step_up ? hr_inc(hour) : hr_dec(hour);
                    SET_MIN:  min  <= step_up ? m60_inc(min) : m60_dec(min);
                    SET_SEC:  sec  <= step_up ? m60_inc(sec) : m60_dec(sec);
                    default:  ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Blink phase: restarts at every mode change, forced low in RUN.
    // ---------------------------------------------------------------
    logic [BL_W-1:0] bl_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bl_cnt  <= '0;
            o_blink <= 1'b0;
        end else if (state == RUN || i_mode) begin
            bl_cnt  <= '0;
            o_blink <= 1'b0;
        end else if (tick) begin
            if (bl_cnt == BL_LAST) begin
                bl_cnt  <= '0;
                o_blink <= ~o_blink;
            end else begin
                bl_cnt <= bl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_watch_set_core.sv
// Directed bench for watch_set_core: a 24h and a 12h instance share all
// inputs; CLK_HZ=1000, TICK_HZ=100 gives a tick every 10 clocks.
module tb_watch_set_core;

    logic       clk, rst, i_mode, i_up, i_down;
    logic [6:0] msec_a, msec_b;
    logic [5:0] sec_a, sec_b, min_a, min_b;
    logic [4:0] hour_a, hour_b;
    logic [1:0] fld_a, fld_b;
    logic       blink_a, blink_b;

    int checks = 0;
    int errors = 0;
    int ec = 0;
    int t0 = 0;

    watch_set_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MODE(24),
                     .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut_a (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_up(i_up), .i_down(i_down),
        .msec(msec_a), .sec(sec_a), .min(min_a), .hour(hour_a),
        .o_set_field(fld_a), .o_blink(blink_a));

    watch_set_core #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MODE(12),
                     .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut_b (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_up(i_up), .i_down(i_down),
        .msec(msec_b), .sec(sec_b), .min(min_b), .hour(hour_b),
        .o_set_field(fld_b), .o_blink(blink_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            ec++;
        end
        #1;
    endtask

    task automatic until_rel(input int r);
        while (ec - t0 < r) step(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_mode();
        i_mode = 1'b1;
        step(1);
        i_mode = 1'b0;
    endtask

    task automatic press_up();
        i_up = 1'b1;
        step(1);
        i_up = 1'b0;
        step(1);
    endtask

    task automatic press_dn();
        i_down = 1'b1;
        step(1);
        i_down = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b0; i_mode = 1'b0; i_up = 1'b0; i_down = 1'b0;
        step(3);
        chk("rst_msec", msec_a, 0);
        chk("rst_sec", sec_a, 0);
        chk("rst_min", min_a, 0);
        chk("rst_hour24", hour_a, 0);
        chk("rst_hour12", hour_b, 12);
        chk("rst_field", fld_a, 0);
        chk("rst_blink", blink_a, 0);

        // first tick a full period after the first edge with rst high
        rst = 1'b1;
        step(10);
        chk("first_tick_pre", msec_a, 0);
        step(1);
        chk("first_tick", msec_a, 1);

        // hour step wrap in both directions
        pulse_mode();
        chk("set_hour_field", fld_a, 1);
        chk("set_msec_held", msec_a, 0);
        press_dn();
        chk("dn_wrap24", hour_a, 23);
        chk("dn_wrap24_min", min_a, 0);
        chk("dn_wrap24_sec", sec_a, 0);
        chk("dn_field", fld_a, 1);
        chk("dn_12h", hour_b, 11);
        press_up();
        chk("up_wrap24", hour_a, 0);
        chk("up_12h", hour_b, 12);
        chk("blink_early", blink_a, 0);

        // 12h: 12:59:59.99 + tick -> 01:00:00.00 (24h: 00:59 -> 01:00)
        pulse_mode();
        chk("set_min_field", fld_a, 2);
        press_dn();
        chk("min_dn_wrap", min_a, 59);
        pulse_mode();
        chk("set_sec_field", fld_a, 3);
        press_dn();
        chk("sec_dn_wrap", sec_a, 59);
        pulse_mode();
        chk("run_field", fld_a, 0);
        step(990);
        chk("pre12_msec", msec_b, 99);
        chk("pre12_hour", hour_b, 12);
        chk("pre24_hour", hour_a, 0);
        step(10);
        chk("roll12_hour", hour_b, 1);
        chk("roll12_min", min_b, 0);
        chk("roll12_sec", sec_b, 0);
        chk("roll12_msec", msec_b, 0);
        chk("roll24_hour", hour_a, 1);

        // 24h: 23:59:59.99 + tick -> 00:00:00.00
        pulse_mode();
        press_dn();
        press_dn();
        chk("hour_23", hour_a, 23);
        pulse_mode();
        press_dn();
        pulse_mode();
        press_dn();
        pulse_mode();
        step(990);
        chk("pre24_all", {hour_a, min_a, sec_a, msec_a}, {5'd23, 6'd59, 6'd59, 7'd99});
        step(10);
        chk("roll24_all", {hour_a, min_a, sec_a, msec_a}, 24'd0);
        t0 = ec;

        // auto-repeat in SET_MIN; ticks fall on edges t0+10k
        pulse_mode();
        pulse_mode();
        press_dn();
        press_dn();
        chk("min_58", min_a, 58);
        i_up = 1'b1;
        step(1);
        chk("rep_edge", min_a, 59);
        until_rel(49);
        chk("rep_pre5", min_a, 59);
        until_rel(50);
        chk("rep_t5", min_a, 0);
        until_rel(69);
        chk("rep_pre7", min_a, 0);
        until_rel(70);
        chk("rep_t7", min_a, 1);
        until_rel(90);
        chk("rep_t9", min_a, 2);
        until_rel(105);
        i_up = 1'b0;
        until_rel(110);
        chk("rep_release", min_a, 2);
        until_rel(499);
        chk("blink_pre", blink_a, 0);
        until_rel(500);
        chk("blink_on", blink_a, 1);

        // mode with step on the same edge: mode wins, step dropped
        i_mode = 1'b1; i_up = 1'b1;
        step(1);
        i_mode = 1'b0; i_up = 1'b0;
        chk("mode_step_field", fld_a, 3);
        chk("mode_step_min", min_a, 2);
        chk("mode_step_sec", sec_a, 0);
        chk("mode_blink_clr", blink_a, 0);
        step(1);

        // both buttons held: no step
        i_up = 1'b1; i_down = 1'b1;
        step(200);
        chk("both_sec", sec_a, 0);
        i_up = 1'b0; i_down = 1'b0;
        step(1);
        pulse_mode();
        chk("back_run", fld_a, 0);
        chk("back_run_blink", blink_a, 0);
        step(9);
        chk("restart_pre", msec_a, 0);
        step(1);
        chk("restart_tick", msec_a, 1);

        // buttons ignored in RUN
        i_up = 1'b1;
        step(3);
        i_up = 1'b0;
        i_down = 1'b1;
        step(3);
        i_down = 1'b0;
        chk("run_ignore", {hour_a, min_a, sec_a}, {5'd0, 6'd2, 6'd0});

        // reset mid-adjust
        pulse_mode();
        i_up = 1'b1;
        step(1);
        chk("adj_hour", hour_a, 1);
        step(20);
        rst = 1'b0;
        #1;
        chk("arst_all", {hour_a, min_a, sec_a, msec_a}, 24'd0);
        chk("arst_field", fld_a, 0);
        chk("arst_blink", blink_a, 0);
        chk("arst_hour12", hour_b, 12);
        step(2);
        rst = 1'b1;
        step(5);
        chk("post_rst_hour", hour_a, 0);
        chk("post_rst_field", fld_a, 0);
        i_up = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
